// File: rtl/cube_field_packer.sv
// Assembles eight 3-bit fields into a 24-bit state word and hands the word to a
// consumer with a valid/ready handshake; repeated writes to a field are flagged.
module cube_field_packer #(
    parameter int          AUTO_CLOSE = 1,
    parameter logic [23:0] CLR_VAL    = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_idx,
    input  logic [2:0]  in_val,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_word,
    output logic [7:0]  out_mask,
    output logic        dup_err
);

    localparam int FIELD_W = 3;

    typedef enum logic {FILL, HOLD} state_t;

    state_t      state_p0;
    logic [23:0] word_p0;
    logic [7:0]  mask_p0;
    logic        dup_p0;

    logic        wr_acc;
    logic        wr_dup;
    logic        wr_close;
    logic [7:0]  mask_nxt;

    function automatic logic [23:0] set_field(input logic [23:0] w,
                                              input logic [2:0]  idx,
                                              input logic [2:0]  v);
        logic [23:0] r;
        r = w;
        r[FIELD_W*int'(idx) +: FIELD_W] = v;
        return r;
    endfunction

    function automatic logic [7:0] idx_bit(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    always_comb begin
        wr_acc   = in_valid && (state_p0 == FILL);
        wr_dup   = mask_p0[in_idx];
        mask_nxt = mask_p0 | idx_bit(in_idx);
        // a duplicate that also completes the frame still closes it
        wr_close = in_last || ((AUTO_CLOSE != 0) && (mask_nxt == 8'hFF));
    end

    // ---- frame state: all outputs come straight from these registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= FILL;
            word_p0  <= CLR_VAL;
            mask_p0  <= 8'h00;
            dup_p0   <= 1'b0;
        end else begin
            dup_p0 <= 1'b0;
            case (state_p0)
                FILL: begin
                    if (wr_acc) begin
                        word_p0 <= set_field(word_p0, in_idx, in_val);
                        mask_p0 <= mask_nxt;
                        dup_p0  <= wr_dup;
                        if (wr_close)
                            state_p0 <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_p0 <= FILL;
                        word_p0  <= CLR_VAL;
                        mask_p0  <= 8'h00;
                    end
                end
                default: state_p0 <= FILL;
            endcase
        end
    end

    assign in_ready  = (state_p0 == FILL);
    assign out_valid = (state_p0 == HOLD);
    assign out_word  = word_p0;
    assign out_mask  = mask_p0;
    assign dup_err   = dup_p0;

endmodule

// File: tb/tb_cube_field_packer.sv
// Bench for cube_field_packer: u1 uses defaults (auto-close), u0 uses
// AUTO_CLOSE=0 with a non-zero clear value; a cycle model predicts both.
module tb_cube_field_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  iv, il, ordy;
    logic [2:0]  ix   [2];
    logic [2:0]  ivl  [2];
    logic [1:0]  rdy, ov, dup;
    logic [23:0] ow   [2];
    logic [7:0]  om   [2];

    localparam logic [23:0] CLR0 = 24'h5A5A5A;

    always #5 clk = ~clk;

    cube_field_packer #(.AUTO_CLOSE(0), .CLR_VAL(CLR0)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(rdy[0]), .in_idx(ix[0]), .in_val(ivl[0]),
        .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_word(ow[0]), .out_mask(om[0]), .dup_err(dup[0]));

    cube_field_packer u1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(rdy[1]), .in_idx(ix[1]), .in_val(ivl[1]),
        .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_word(ow[1]), .out_mask(om[1]), .dup_err(dup[1]));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model
    int          mst  [2];
    logic [23:0] mw   [2];
    logic [7:0]  mm   [2];
    logic [1:0]  mdup;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    function automatic logic [23:0] clr_of(input int s);
        return (s == 0) ? CLR0 : 24'h000000;
    endfunction

    task automatic push_exp(input int s, input logic [31:0] v);
        if (s == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            mst[s] = 0; mw[s] = clr_of(s); mm[s] = 8'h00;
        end
        mdup = 2'b00;
    end

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                mst[s] = 0; mw[s] = clr_of(s); mm[s] = 8'h00; mdup[s] = 1'b0;
                if (s == 0) q0.delete(); else q1.delete();
            end else begin
                mdup[s] = 1'b0;
                if (mst[s] == 0 && iv[s]) begin
                    mdup[s] = (mm[s] & (8'd1 << ix[s])) != 8'h00;
                    mw[s] = (mw[s] & ~(24'h7 << (3 * ix[s]))) | ({21'd0, ivl[s]} << (3 * ix[s]));
                    mm[s] = mm[s] | (8'd1 << ix[s]);
                    if (il[s] || (s == 1 && mm[s] == 8'hFF)) begin
                        mst[s] = 1;
                        push_exp(s, {mm[s], mw[s]});
                    end
                end else if (mst[s] == 1 && ordy[s]) begin
                    mst[s] = 0; mw[s] = clr_of(s); mm[s] = 8'h00;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                logic [31:0] e;
                check($sformatf("in_ready[%0d]", s), {31'd0, rdy[s]}, {31'd0, mst[s] == 0});
                check($sformatf("out_valid[%0d]", s), {31'd0, ov[s]}, {31'd0, mst[s] == 1});
                check($sformatf("dup_err[%0d]", s), {31'd0, dup[s]}, {31'd0, mdup[s]});
                check($sformatf("word[%0d]", s), {8'd0, ow[s]}, {8'd0, mw[s]});
                check($sformatf("mask[%0d]", s), {24'd0, om[s]}, {24'd0, mm[s]});
                if (ov[s] && ordy[s]) begin
                    if ((s == 0 ? q0.size() : q1.size()) == 0) begin
                        check($sformatf("sb_empty[%0d]", s), 32'd1, 32'd0);
                    end else begin
                        e = (s == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("sb_word[%0d]", s), {8'd0, ow[s]}, {8'd0, e[23:0]});
                        check($sformatf("sb_mask[%0d]", s), {24'd0, om[s]}, {24'd0, e[31:24]});
                    end
                end
            end
        end
    end

    task automatic write(input int s, input logic [2:0] idx, input logic [2:0] val, input logic last);
        bit acc = 1'b0;
        iv[s] = 1'b1; ix[s] = idx; ivl[s] = val; il[s] = last;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = (mst[s] == 0);
            @(posedge clk); #1;
        end
        if (!acc) check("write_timeout", 32'd0, 32'd1);
        iv[s] = 1'b0; il[s] = 1'b0;
    endtask

    task automatic handshake(input int s, input int delay);
        repeat (delay) @(posedge clk);
        #1 ordy[s] = 1'b1;
        @(posedge clk); #1 ordy[s] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iv = '0; il = '0; ordy = '0;
        for (int s = 0; s < 2; s++) begin ix[s] = '0; ivl[s] = '0; end
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        idle(1);

        // full frame, auto close
        for (int k = 0; k < 8; k++)
            write(1, 3'(k), (k == 7) ? 3'd5 : 3'(k + 1), 1'b0);
        idle(2);
        handshake(1, 0);

        // single field with in_last
        write(1, 3'd2, 3'd3, 1'b1);
        handshake(1, 1);

        // held word with producer pushing; the pending write lands right after the handshake
        write(1, 3'd0, 3'd1, 1'b1);
        iv[1] = 1'b1; ix[1] = 3'd5; ivl[1] = 3'd4;
        idle(5);
        ordy[1] = 1'b1;
        idle(1);
        ordy[1] = 1'b0;
        idle(1);
        iv[1] = 1'b0;
        write(1, 3'd6, 3'd7, 1'b1);
        handshake(1, 0);

        // duplicate mid-frame, then duplicate on the closing write
        write(1, 3'd4, 3'd2, 1'b0);
        write(1, 3'd4, 3'd6, 1'b0);
        write(1, 3'd0, 3'd3, 1'b1);
        handshake(1, 0);
        write(1, 3'd4, 3'd2, 1'b0);
        write(1, 3'd4, 3'd6, 1'b1);
        handshake(1, 2);

        // reset mid-frame and reset against a pending handshake
        write(1, 3'd1, 3'd1, 1'b0);
        write(1, 3'd2, 3'd2, 1'b0);
        write(1, 3'd3, 3'd3, 1'b0);
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        write(1, 3'd7, 3'd6, 1'b1);
        idle(1);
        rst = 1'b1; ordy[1] = 1'b1; idle(1);
        rst = 1'b0; ordy[1] = 1'b0; idle(2);

        // no auto close: full mask stays open until in_last; unwritten fields keep the clear value
        for (int k = 0; k < 8; k++)
            write(0, 3'(k), 3'(7 - k), 1'b0);
        idle(3);
        write(0, 3'd3, 3'd1, 1'b1);
        handshake(0, 1);
        write(0, 3'd6, 3'd0, 1'b1);
        handshake(0, 0);

        // random traffic on the auto-close instance
        for (int n = 0; n < 200; n++) begin
            write(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 5) == 0);
            if (mst[1] == 1) handshake(1, $urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(4);
        check("sb_left0", q0.size(), 32'd0);
        check("sb_left1", q1.size(), 32'd0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
